mdu_seq: RTL and testbench

- Multi-cycle multiply/divide sequencer that owns the HI/LO register pair.
- Executes MULTU and DIVU iteratively, one bit per cycle.
- Raises a stall interlock toward the core for MFHI/MFLO reads and new starts while an operation is in flight.
- Sits beside the ALU in the execute stage and replaces single-cycle HI/LO writes.

---
 rtl/mdu_seq.sv | 137 +++++++++++++
 tb/tb_mdu_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// Multi-cycle unsigned multiply/divide sequencer owning the HI/LO register pair.
// MULTU uses shift-add, DIVU uses restoring division; one bit per clock.
module mdu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             flush,
  input  logic             mf_req,
  input  logic             mf_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int unsigned    CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               op_q, op_d;
  // Multiplicand for MULTU, divisor for DIVU.
  logic [WIDTH-1:0]   opb_q, opb_d;
  // MULTU: {partial product, remaining multiplier}; DIVU: {remainder, quotient}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_rem_sh;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] step_next;

  // One iteration of the active algorithm, computed from the current accumulator.
  always_comb begin
    mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    // Shifted remainder needs one extra bit: it can reach 2*divisor-1.
    div_rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff   = div_rem_sh - {1'b0, opb_q};
    div_ge     = (div_rem_sh >= {1'b0, opb_q});
    if (op_q) begin
      step_next = div_ge ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                         : {div_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      step_next = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  // Next-state, accept, iterate and commit logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (flush) begin
          state_d = StIdle;
        end else if (start) begin
          op_d  = op;
          cnt_d = '0;
          if (op && (rt == '0)) begin
            // Divide by zero finishes immediately with a fixed result.
            hi_d    = rs;
            lo_d    = '1;
            acc_d   = '0;
            state_d = StDone;
          end else begin
            opb_d   = op ? rt : rs;
            acc_d   = {{WIDTH{1'b0}}, (op ? rs : rt)};
            state_d = StRun;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          acc_d = step_next;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            hi_d    = step_next[2*WIDTH-1:WIDTH];
            lo_d    = step_next[WIDTH-1:0];
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      opb_q   <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Status, interlock and read-port outputs.
  always_comb begin
    busy    = (state_q == StRun);
    done    = (state_q == StDone);
    stall   = (state_q == StRun) && (mf_req || start);
    hi      = hi_q;
    lo      = lo_q;
    rd_data = mf_sel ? lo_q : hi_q;
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: vector table plus hand-written multi-cycle sequences.
module tb_mdu_seq;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         op;
  logic [W-1:0] rs;
  logic [W-1:0] rt;
  logic         flush;
  logic         mf_req;
  logic         mf_sel;
  logic [W-1:0] rd_data;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
  logic         stall;

  int total;
  int bad;

  mdu_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .rs      (rs),
    .rt      (rt),
    .flush   (flush),
    .mf_req  (mf_req),
    .mf_sel  (mf_sel),
    .rd_data (rd_data),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done),
    .stall   (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         vop;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    int           exp_busy;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Called at the negedge right after the accepting edge; returns at the negedge where done=1.
  task automatic wait_done(output int busy_cyc);
    int guard;
    busy_cyc = 0;
    guard    = 0;
    while (!done && guard < 100) begin
      if (busy) busy_cyc++;
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic issue(input logic vop, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = vop;
    rs    = a;
    rt    = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int bc;
    int cnt;
    int seen;
    total  = 0;
    bad    = 0;

    vecs[0] = '{1'b0, 32'd7,         32'd6,         32'h0000_0000, 32'h0000_002A, 32};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32};
    vecs[2] = '{1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 32};
    vecs[3] = '{1'b0, 32'h1234_5678, 32'd0,         32'h0000_0000, 32'h0000_0000, 32};
    vecs[4] = '{1'b0, 32'h8000_0000, 32'd2,         32'h0000_0001, 32'h0000_0000, 32};
    vecs[5] = '{1'b1, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 32};
    vecs[6] = '{1'b1, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF, 32};
    vecs[7] = '{1'b1, 32'd5,         32'd10,        32'h0000_0005, 32'h0000_0000, 32};
    vecs[8] = '{1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 32};
    vecs[9] = '{1'b1, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 0};

    rst_n  = 1'b0;
    start  = 1'b0;
    op     = 1'b0;
    rs     = '0;
    rt     = '0;
    flush  = 1'b0;
    mf_req = 1'b0;
    mf_sel = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_stall", {31'b0, stall}, 32'h0);
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].vop, vecs[i].a, vecs[i].b);
      wait_done(bc);
      check($sformatf("v%0d_done", i), {31'b0, done}, 32'h1);
      check($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
      check($sformatf("v%0d_rd_hi", i), rd_data, vecs[i].exp_hi);
      check($sformatf("v%0d_busy_cycles", i), bc, vecs[i].exp_busy);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), {31'b0, done}, 32'h0);
    end

    // Back-to-back: DIVU started in the DONE cycle of a MULTU.
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(bc);
    check("b2b_mul_hi", hi, 32'hFFFF_FFFE);
    check("b2b_mul_lo", lo, 32'h0000_0001);
    start = 1'b1;
    op    = 1'b1;
    rs    = 32'd100;
    rt    = 32'd7;
    @(negedge clk);
    start = 1'b0;
    check("b2b_no_gap_busy", {31'b0, busy}, 32'h1);
    wait_done(bc);
    check("b2b_div_hi", hi, 32'd2);
    check("b2b_div_lo", lo, 32'd14);
    check("b2b_div_busy_cycles", bc, 32);

    // MFLO held during a multiply: stall every RUN cycle, none in DONE.
    issue(1'b0, 32'd3, 32'd5);
    mf_req = 1'b1;
    mf_sel = 1'b1;
    cnt    = 0;
    seen   = 0;
    while (!done && seen < 100) begin
      if (busy && stall) cnt++;
      @(negedge clk);
      seen++;
    end
    check("mf_stall_cycles", cnt, 32);
    check("mf_done_stall", {31'b0, stall}, 32'h0);
    check("mf_rd_lo", rd_data, 32'd15);
    mf_sel = 1'b0;
    #1;
    check("mf_rd_hi", rd_data, 32'd0);
    mf_req = 1'b0;

    // Repeated start during RUN is ignored but stalls.
    issue(1'b0, 32'd7, 32'd6);
    for (int k = 0; k < 5; k++) begin
      start = 1'b1;
      op    = 1'b1;
      rs    = 32'd1;
      rt    = 32'd1;
      #1;
      check($sformatf("rep_stall%0d", k), {31'b0, stall}, 32'h1);
      @(negedge clk);
    end
    start = 1'b0;
    wait_done(bc);
    check("rep_hi", hi, 32'd0);
    check("rep_lo", lo, 32'd42);
    check("rep_busy_cycles", bc, 27);

    // Flush mid-multiply keeps prior HI/LO.
    issue(1'b1, 32'd59, 32'd6);
    wait_done(bc);
    check("pre_flush_hi", hi, 32'd5);
    check("pre_flush_lo", lo, 32'd9);
    issue(1'b0, 32'd7, 32'd6);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'h0);
    seen = 0;
    repeat (40) begin
      if (done) seen++;
      @(negedge clk);
    end
    check("flush_no_done", seen, 0);
    check("flush_hi", hi, 32'd5);
    check("flush_lo", lo, 32'd9);

    // Flush beats start while idle.
    flush = 1'b1;
    start = 1'b1;
    op    = 1'b0;
    rs    = 32'd7;
    rt    = 32'd6;
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    check("flush_start_busy", {31'b0, busy}, 32'h0);
    check("flush_start_done", {31'b0, done}, 32'h0);
    @(negedge clk);
    check("flush_start_busy2", {31'b0, busy}, 32'h0);

    // Asynchronous reset mid-RUN clears HI/LO without a clock edge.
    issue(1'b0, 32'd7, 32'd6);
    repeat (4) @(negedge clk);
    check("pre_rst_busy", {31'b0, busy}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_hi", hi, 32'h0);
    check("arst_lo", lo, 32'h0);
    check("arst_busy", {31'b0, busy}, 32'h0);
    check("arst_done", {31'b0, done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequencer works normally after reset.
    issue(1'b0, 32'd7, 32'd6);
    wait_done(bc);
    check("post_rst_done", {31'b0, done}, 32'h1);
    check("post_rst_lo", lo, 32'd42);
    check("post_rst_busy_cycles", bc, 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
